// File: rtl/bmat_pkg.sv
// bmat_pkg
// Shared types and constants for the bit-matrix unit scheduler.
//   XLEN        : operand / result width of the bit-matrix unit.
//   ID_MAXW     : storage width of a requester index (NREQ is at most 4).
//   tag_t       : in-flight tag travelling alongside the unit pipeline.
//   rsp_entry_t : response FIFO entry (requester index + result).
package bmat_pkg;

    localparam int XLEN    = 64;
    localparam int ID_MAXW = 2;

    typedef struct packed {
        logic               valid;
        logic [ID_MAXW-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [ID_MAXW-1:0] id;
        logic [XLEN-1:0]    rd;
    } rsp_entry_t;

endpackage

// File: rtl/bmat_rsp_fifo.sv
// bmat_rsp_fifo
// Synchronous response FIFO with DEPTH entries. DEPTH need not be a power
// of two, so both pointers wrap explicitly. Push and pop on the same edge
// are accepted at any occupancy; a pop on an empty FIFO is ignored.
// Ports:
//   clock, resetn : rising-edge clock, synchronous active-low reset
//   i_push        : write i_push_data at the tail
//   i_push_data   : entry to store
//   i_pop         : remove the head entry
//   o_head        : current head entry (valid when !o_empty)
//   o_count       : number of stored entries, 0..DEPTH
//   o_empty       : no entries stored
module bmat_rsp_fifo
    import bmat_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            i_push,
    input  rsp_entry_t      i_push_data,
    input  logic            i_pop,
    output rsp_entry_t      o_head,
    output logic [CNTW-1:0] o_count,
    output logic            o_empty
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t      r_mem [DEPTH];
    logic [PTRW-1:0] r_wr_ptr;
    logic [PTRW-1:0] r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            w_pop;
    logic            w_full;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CNTW'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy is tracked by r_count.
    always_ff @(posedge clock) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // The upstream credit scheme must never let a push land on a full FIFO
    // unless the head leaves on the same edge.
    a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
        !(i_push && w_full && !w_pop));

endmodule

// File: rtl/bmat_sched.sv
// bmat_sched
// Shares one fixed-latency, non-stallable bit-matrix unit between NREQ
// requesters. A round-robin arbiter issues at most one op per cycle; a tag
// shift register follows each op through the unit so its result can be
// captured into a response FIFO in issue order. Issue is credit-gated on
// (ops in flight + FIFO occupancy) so a captured result always has room.
// Ports:
//   clock, resetn          : rising-edge clock, synchronous active-low reset
//   req_valid/ready        : per-requester handshake (one-hot ready)
//   req_xor/rs1/rs2        : per-requester operands, 64-bit lanes packed
//   bmat_xoren/rs1/rs2     : registered operands to the bit-matrix unit
//   bmat_rd                : unit result, LATENCY edges after operands
//   rsp_valid/ready/id/rd  : in-order response channel
//   busy                   : work in flight or buffered
module bmat_sched
    import bmat_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int IDW     = 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_xor,
    input  logic [XLEN*NREQ-1:0] req_rs1,
    input  logic [XLEN*NREQ-1:0] req_rs2,
    output logic                 bmat_xoren,
    output logic [XLEN-1:0]      bmat_rs1,
    output logic [XLEN-1:0]      bmat_rs2,
    input  logic [XLEN-1:0]      bmat_rd,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [XLEN-1:0]      rsp_rd,
    output logic                 busy
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IFW  = $clog2(LATENCY + 2);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [PW-1:0]        r_ptr;
    logic [IFW-1:0]       r_inflight;
    tag_t [LATENCY:0]     r_tags;
    logic                 r_bmat_xoren;
    logic [XLEN-1:0]      r_bmat_rs1;
    logic [XLEN-1:0]      r_bmat_rs2;

    logic [XLEN-1:0]      w_rs1 [NREQ];
    logic [XLEN-1:0]      w_rs2 [NREQ];
    logic                 w_found;
    logic [PW-1:0]        w_winner;
    logic [PW:0]          w_sum;
    logic [PW-1:0]        w_idx;
    logic [PW-1:0]        w_ptr_next;
    logic                 w_credit_ok;
    logic                 w_issue;
    logic                 w_capture;
    tag_t                 w_new_tag;
    rsp_entry_t           w_push_data;
    rsp_entry_t           w_head;
    logic [CNTW-1:0]      w_fifo_count;
    logic                 w_fifo_empty;
    logic                 w_pop;

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign w_rs1[g] = req_rs1[XLEN*g +: XLEN];
        assign w_rs2[g] = req_rs2[XLEN*g +: XLEN];
    end

    // Round-robin search starting at r_ptr, wrapping modulo NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_sum = w_sum - (PW+1)'(NREQ);
            end
            w_idx = w_sum[PW-1:0];
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // A pop on this edge does not return credit until the next cycle.
    assign w_credit_ok = (int'(r_inflight) + int'(w_fifo_count)) < DEPTH;
    assign w_issue     = w_found & w_credit_ok & resetn;
    assign req_ready   = w_issue ? (NREQ'(1) << w_winner) : '0;
    assign w_ptr_next  = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + PW'(1);

    assign w_new_tag.valid = w_issue;
    assign w_new_tag.id    = w_issue ? ID_MAXW'(w_winner) : '0;

    // The oldest tag slot lines up with bmat_rd for the op it describes.
    assign w_capture   = r_tags[LATENCY].valid;
    assign w_push_data = '{id: r_tags[LATENCY].id, rd: bmat_rd};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_ptr        <= '0;
            r_inflight   <= '0;
            r_tags       <= '0;
            r_bmat_xoren <= 1'b0;
            r_bmat_rs1   <= '0;
            r_bmat_rs2   <= '0;
        end else begin
            if (w_issue) begin
                r_bmat_xoren <= req_xor[w_winner];
                r_bmat_rs1   <= w_rs1[w_winner];
                r_bmat_rs2   <= w_rs2[w_winner];
                r_ptr        <= w_ptr_next;
            end
            r_tags <= {r_tags[LATENCY-1:0], w_new_tag};
            case ({w_issue, w_capture})
                2'b10:   r_inflight <= r_inflight + IFW'(1);
                2'b01:   r_inflight <= r_inflight - IFW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign bmat_xoren = r_bmat_xoren;
    assign bmat_rs1   = r_bmat_rs1;
    assign bmat_rs2   = r_bmat_rs2;

    assign w_pop = rsp_valid & rsp_ready;

    bmat_rsp_fifo #(
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) u_fifo (
        .clock       (clock),
        .resetn      (resetn),
        .i_push      (w_capture),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty)
    );

    assign rsp_valid = ~w_fifo_empty;
    assign rsp_id    = IDW'(w_head.id);
    assign rsp_rd    = w_head.rd;
    assign busy      = (r_inflight != '0) | (w_fifo_count != '0);

endmodule

// File: tb/tb_bmat_sched.sv
module tb_bmat_sched;

    localparam int NREQ    = 2;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;
    localparam int IDW     = 1;

    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] IDENT = 64'h8040_2010_0804_0201;
    localparam logic [63:0] PATX  = 64'h0123_4567_89AB_CDEF;

    logic                 clock = 1'b0;
    logic                 resetn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_xor;
    logic [64*NREQ-1:0]   req_rs1;
    logic [64*NREQ-1:0]   req_rs2;
    logic                 bmat_xoren;
    logic [63:0]          bmat_rs1;
    logic [63:0]          bmat_rs2;
    logic [63:0]          bmat_rd;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [63:0]          rsp_rd;
    logic                 busy;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    always #5 clock = ~clock;

    bmat_sched #(
        .NREQ(NREQ), .LATENCY(LATENCY), .DEPTH(DEPTH), .IDW(IDW)
    ) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_xor(req_xor),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .bmat_xoren(bmat_xoren), .bmat_rs1(bmat_rs1), .bmat_rs2(bmat_rs2),
        .bmat_rd(bmat_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_rd(rsp_rd), .busy(busy)
    );

    // Bit-matrix product: result bit (8r+c) combines row r of a with column c of b.
    function automatic logic [63:0] bmat_f(input logic x, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic p, o;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                p = 1'b0;
                o = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    p = p ^ (a[8*i+k] & b[8*k+j]);
                    o = o | (a[8*i+k] & b[8*k+j]);
                end
                r[8*i+j] = x ? p : o;
            end
        end
        return r;
    endfunction

    // Stand-in for the two-stage bit-matrix unit.
    logic [63:0] stub_s1;
    always @(posedge clock) begin
        stub_s1 <= bmat_f(bmat_xoren, bmat_rs1, bmat_rs2);
        bmat_rd <= stub_s1;
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Reference model: outstanding ops in a queue, each becoming visible
    // LATENCY+1 edges after its handshake.
    typedef struct {
        int          id;
        logic [63:0] rd;
        int          avail;
    } exp_t;
    exp_t mq[$];

    initial begin
        int cyc, m_ptr, m_out, win, idx;
        logic [NREQ-1:0] e_rdy;
        logic e_val, hs, pop;
        exp_t e;
        cyc = 0; m_ptr = 0; m_out = 0;
        e = '{id: 0, rd: '0, avail: 0};
        wait (started);
        forever begin
            @(negedge clock);
            e_rdy = '0;
            win = -1;
            if (resetn === 1'b1 && m_out < DEPTH) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
            end
            if (win >= 0) e_rdy[win] = 1'b1;
            chk("req_ready", req_ready, e_rdy);
            e_val = (mq.size() > 0) && (mq[0].avail <= cyc);
            chk("rsp_valid", rsp_valid, e_val);
            if (e_val) begin
                chk("rsp_id", rsp_id, mq[0].id);
                chk("rsp_rd", rsp_rd, mq[0].rd);
            end
            chk("busy", busy, m_out != 0);
            hs  = (win >= 0);
            pop = e_val && rsp_ready;
            if (hs) e = '{id: win, rd: bmat_f(req_xor[win], req_rs1[64*win +: 64], req_rs2[64*win +: 64]), avail: 0};
            @(posedge clock);
            cyc++;
            if (!resetn) begin
                mq.delete();
                m_ptr = 0;
                m_out = 0;
            end else begin
                if (pop) begin
                    void'(mq.pop_front());
                    m_out--;
                end
                if (hs) begin
                    e.avail = cyc + LATENCY + 1;
                    mq.push_back(e);
                    m_out++;
                    m_ptr = (win + 1) % NREQ;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int r, input logic x, input logic [63:0] a, input logic [63:0] b);
        req_xor[r] = x;
        req_rs1[64*r +: 64] = a;
        req_rs2[64*r +: 64] = b;
    endtask

    task automatic rand_req(input int r);
        set_req(r, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        @(negedge clock);
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        @(negedge clock);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("drain_busy", busy, 1'b0);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, nhs, npop, nvis;
        int grants[$];

        resetn = 1'b0; req_valid = 2'b11; req_xor = '0;
        req_rs1 = '0; req_rs2 = '0; rsp_ready = 1'b1;

        chk("model_or_ones", bmat_f(1'b0, ONES, ONES), ONES);
        chk("model_xor_ones", bmat_f(1'b1, ONES, ONES), 64'h0);
        chk("model_identity", bmat_f(1'b1, IDENT, PATX), PATX);

        tick(); tick();
        started = 1'b1;
        @(negedge clock);
        chk("rst_xoren", bmat_xoren, 1'b0);
        chk("rst_rs1", bmat_rs1, 64'h0);
        chk("rst_rs2", bmat_rs2, 64'h0);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        tick();
        resetn = 1'b1; req_valid = '0;

        // single ops
        set_req(0, 1'b0, ONES, ONES);
        req_valid = 2'b01;
        @(negedge clock);
        chk("p1_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        chk("p1_bmat_rs1", bmat_rs1, ONES);
        chk("p1_bmat_xoren", bmat_xoren, 1'b0);
        wait_rsp(lat);
        chk("p1_latency", lat, 3);
        chk("p1_id", rsp_id, 0);
        chk("p1_rd", rsp_rd, ONES);
        tick();
        set_req(0, 1'b0, 64'h0, 64'h0);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        wait_rsp(lat);
        chk("p1_zero_rd", rsp_rd, 64'h0);
        tick();
        set_req(1, 1'b1, IDENT, PATX);
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        wait_rsp(lat);
        chk("p1_r1_id", rsp_id, 1);
        chk("p1_r1_rd", rsp_rd, PATX);
        tick();

        // both requesters streaming from a fresh pointer
        drain(30);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req_valid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            rand_req(0);
            rand_req(1);
            @(negedge clock);
            if (req_ready[0]) grants.push_back(0);
            else if (req_ready[1]) grants.push_back(1);
            tick();
        end
        req_valid = '0;
        chk("p2_ngrants", grants.size() >= 8, 1'b1);
        for (int i = 0; i < grants.size() && i < 8; i++) chk("p2_grant_order", grants[i], i % 2);

        // stalled response channel fills the credit window
        drain(30);
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        nhs = 0;
        for (int c = 0; c < 12; c++) begin
            rand_req(0);
            @(negedge clock);
            if (req_ready[0]) nhs++;
            tick();
        end
        chk("p3_handshakes", nhs, 4);
        @(negedge clock);
        chk("p3_ready_low", req_ready, 2'b00);
        tick();
        rsp_ready = 1'b1;
        npop = 0; nhs = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (rsp_valid && rsp_ready) npop++;
            if (req_ready[0]) nhs++;
            tick();
        end
        chk("p3_drained", npop, 4);
        chk("p3_resumed", nhs > 0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            rand_req(0);
            tick();
        end

        // reset with ops in flight and buffered
        drain(30);
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        for (int c = 0; c < 4; c++) begin
            rand_req(0);
            tick();
        end
        req_valid = '0;
        tick();
        chk("p4_buffered", rsp_valid, 1'b1);
        chk("p4_busy_before", busy, 1'b1);
        resetn = 1'b0;
        rsp_ready = 1'b1;
        tick();
        resetn = 1'b1;
        chk("p4_rsp_valid_after", rsp_valid, 1'b0);
        chk("p4_busy_after", busy, 1'b0);
        nvis = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (rsp_valid) nvis++;
            tick();
        end
        chk("p4_no_stale", nvis, 0);
        req_valid = 2'b11;
        @(negedge clock);
        chk("p4_first_grant", req_ready, 2'b01);
        tick();
        req_valid = '0;

        // lone requester 1 with pointer at 0
        drain(30);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req_valid = 2'b10;
        @(negedge clock);
        chk("p5_grant1", req_ready, 2'b10);
        tick();
        req_valid = 2'b11;
        @(negedge clock);
        chk("p5_ptr_wrap", req_ready, 2'b01);
        tick();
        req_valid = '0;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if ($urandom_range(0, 5) == 0) set_req(r, 1'($urandom_range(0, 1)), ONES, ($urandom_range(0, 1) != 0) ? ONES : IDENT);
                else rand_req(r);
                req_valid[r] = ($urandom_range(0, 9) < 6);
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            resetn = ($urandom_range(0, 299) != 0);
            tick();
        end
        resetn = 1'b1;
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bmat_sched.md
Name: bmat_sched

Overview:
- Shares one pipelined bit-matrix unit (simplebmat: xoren/rs1/rs2 in, rd out, fixed 2-cycle latency, no stall input) between NREQ requesters.
- Round-robin arbitration, one issue per cycle.
- Tracks in-flight operations and their requester IDs through the unit's latency.
- Returns results in issue order on a single valid/ready response channel through a credit-protected FIFO, because the bmat pipeline cannot be back-pressured.

Parameters:
- NREQ, 2, number of requesters (2..4).
- LATENCY, 2, clock edges from bmat_* change to bmat_rd valid.
- DEPTH, 4, response FIFO entries; must be >= LATENCY+1.
- IDW, 1, response ID width; must be >= clog2(NREQ).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept.
- req_xor  in  NREQ  per-requester xoren (1 = bmatxor, 0 = bmator).
- req_rs1  in  64*NREQ  operand rs1, requester i at [64*i+63:64*i].
- req_rs2  in  64*NREQ  operand rs2, same packing.
- bmat_xoren  out  1  registered to simplebmat.xoren.
- bmat_rs1  out  64  registered to simplebmat.rs1.
- bmat_rs2  out  64  registered to simplebmat.rs2.
- bmat_rd  in  64  from simplebmat.rd.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  requester index of the response.
- rsp_rd  out  64  result.
- busy  out  1  any op in flight or FIFO non-empty.

Behaviour:
- Reset (resetn=0 at a rising edge):
  - Flush the tag pipeline and the FIFO; zero the counters.
  - RR pointer points at requester 0.
  - bmat_xoren, bmat_rs1 and bmat_rs2 go to 0; rsp_valid=0 and busy=0.
  - req_ready is 0 while resetn=0.
  - A reset mid-operation discards every in-flight and buffered result. No response for those ops ever appears.
- Credit:
  - credit_ok = (inflight + fifo_count) < DEPTH, where inflight = number of tags in the pipeline.
  - A same-cycle pop gives no credit back. This is conservative by design.
- Arbitration (combinational):
  - Search order is ptr, ptr+1, …, wrapping modulo NREQ; the first requester with req_valid set wins.
  - req_ready[i] = (i == winner) & credit_ok & resetn. At most one bit is set.
- Issue, on handshake at edge E:
  - Register the winner's xor/rs1/rs2 into bmat_*.
  - Push tag {valid=1, id=i} into an LATENCY+1-deep shift register.
  - ptr <= winner+1 mod NREQ.
  - With no issue: bmat_* hold their value, a valid=0 tag shifts in, and ptr is unchanged.
- Capture:
  - When a valid tag leaves the shift register (edge E+LATENCY+1), push {id, bmat_rd} into the FIFO.
  - rsp_valid asserts after that edge. Minimum request-to-rsp_valid is LATENCY+1 cycles (3 by default).
  - Back-to-back issues sustain 1 op/cycle while rsp_ready=1.
- Response:
  - FIFO head drives rsp_id and rsp_rd, registered or from the head entry, stable while rsp_valid & !rsp_ready.
  - Pop when rsp_valid & rsp_ready.
  - Push and pop on the same edge are legal at any occupancy, including full.
  - Push on overflow cannot occur because of the credit rule; an assertion flags it.
- Ordering: responses come out strictly in issue order, across all requesters.
- busy = (inflight != 0) | (fifo_count != 0).
- Counter widths: inflight 0..LATENCY+1 and fifo_count 0..DEPTH. The FIFO pointers wrap modulo DEPTH; DEPTH is not restricted to a power of 2, so the wrap is explicit.

Decomposition:
- Package bmat_pkg holds:
  - the XLEN=64 constant;
  - the tag typedef {valid, id[IDW-1:0]};
  - the response-entry typedef {id, rd[63:0]}.
- Sub-module bmat_rsp_fifo: synchronous FIFO with DEPTH entries, count output, push/pop same-cycle support.
- simplebmat is not instantiated inside bmat_sched; the parent or the bench wires it.

Test Plan:
- Single op, requester 0:
  - Stimulus: xor=0, rs1=rs2=0xFFFFFFFFFFFFFFFF, rsp_ready=1.
  - Response: rsp_valid 3 cycles after the handshake, rsp_id=0, rsp_rd=0xFFFFFFFFFFFFFFFF.
  - Then zero operands give rd=0.
- Both requesters valid continuously for 8 cycles, rsp_ready=1:
  - Grants alternate 0,1,0,1… starting with 0 after reset.
  - Every rsp_rd matches the simplebmat golden model (testdata_bmat vectors) in issue order.
- rsp_ready=0, requester 0 streaming:
  - Exactly DEPTH=4 handshakes, after which req_ready stays 0.
  - Raising rsp_ready drains 4 responses in order, and issue resumes.
- FIFO full with rsp_ready=1 and requester valid:
  - Simultaneous pop and capture keep fifo_count constant with no loss.
  - No overflow assertion fires.
- Reset mid-stream:
  - Stimulus: resetn=0 for 1 cycle with 2 ops in flight and 2 buffered.
  - Response: rsp_valid=0 and busy=0 next cycle; no stale response ever appears; the next grant goes to requester 0.
- Requester 1 alone valid while ptr=0: immediate grant to 1; ptr becomes 0.
